// File: rtl/avalon_mem_fill_check_master_if.sv
// Avalon-MM master/slave bus bundle used by the fill-and-check memory test engine.
interface avalon_mem_fill_check_master_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest;
   logic [31:0]       avm_readdata;
   logic              avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );
endinterface

// File: rtl/avalon_mem_fill_check_master.sv
// Built-in memory test engine: writes seed+i over a word range, reads it back and
// reports pass/fail, a saturating error count and the first failing byte address.
module avalon_mem_fill_check_master #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 14,
   parameter int unsigned ERR_W  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [CNT_W-1:0]               word_count,
   input  logic [31:0]                    seed,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [ERR_W-1:0]               err_count,
   output logic [ADDR_W-1:0]              first_err_addr,
   avalon_mem_fill_check_master_if.master avm
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StWrite  = 3'd1;
   localparam logic [2:0] StRdReq  = 3'd2;
   localparam logic [2:0] StRdWait = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       seed_q, seed_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic              pass_q, pass_d;

   logic [CNT_W-1:0]  next_idx;
   logic              last;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_data;
   logic              mismatch;

   assign next_idx = idx_q + CNT_W'(1);
   assign last     = (next_idx == cnt_q);
   assign cur_addr = base_q + ADDR_W'({idx_q, 2'b00});
   assign cur_data = seed_q + 32'(idx_q);
   assign mismatch = (avm.avm_readdata != cur_data);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      idx_d   = idx_q;
      err_d   = err_q;
      first_d = first_q;
      pass_d  = pass_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StWrite;
               base_d  = {base_addr[ADDR_W-1:2], 2'b00};
               cnt_d   = word_count;
               seed_d  = seed;
               idx_d   = '0;
               err_d   = '0;
               first_d = '0;
               pass_d  = 1'b0;
            end
         end
         StWrite: begin
            // An empty range still spends one cycle here, so done lands 2 cycles after start.
            if (cnt_q == '0) begin
               state_d = StDone;
               pass_d  = 1'b1;
            end else if (!avm.avm_waitrequest) begin
               if (last) begin
                  idx_d   = '0;
                  state_d = StRdReq;
               end else begin
                  idx_d = next_idx;
               end
            end
         end
         StRdReq: begin
            if (!avm.avm_waitrequest) state_d = StRdWait;
         end
         StRdWait: begin
            if (avm.avm_readdatavalid) begin
               if (mismatch) begin
                  if (!(&err_q)) err_d = err_q + ERR_W'(1);
                  if (err_q == '0) first_d = cur_addr;
               end
               if (last) begin
                  state_d = StDone;
                  pass_d  = (err_q == '0) && !mismatch;
               end else begin
                  idx_d   = next_idx;
                  state_d = StRdReq;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         base_q  <= '0;
         cnt_q   <= '0;
         seed_q  <= '0;
         idx_q   <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end
   end

   assign busy           = (state_q == StWrite) || (state_q == StRdReq) || (state_q == StRdWait);
   assign done           = (state_q == StDone);
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;

   assign avm.avm_address    = cur_addr;
   assign avm.avm_writedata  = cur_data;
   assign avm.avm_byteenable = 4'hF;
   assign avm.avm_write      = (state_q == StWrite) && (cnt_q != '0);
   assign avm.avm_read       = (state_q == StRdReq);

endmodule

// File: tb/tb_avalon_mem_fill_check_master.sv
// Self-checking bench: randomized RAM slave (stalls, read latency, corruption, stray
// readdatavalid) with an arithmetic reference model of the expected fill/check outcome.
module tb_avalon_mem_fill_check_master;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CNT_W  = 14;
   localparam int unsigned ERR_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic [31:0]       seed;
   logic              busy, done, pass;
   logic [ERR_W-1:0]  err_count;
   logic [ADDR_W-1:0] first_err_addr;

   always #5 clk = ~clk;

   avalon_mem_fill_check_master_if #(.ADDR_W(ADDR_W)) avm ();

   avalon_mem_fill_check_master #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W),
      .ERR_W (ERR_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .seed          (seed),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_addr(first_err_addr),
      .avm           (avm)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model configuration and per-run state
   int          wait_pct = 0;
   int          rd_lat   = 1;
   bit          spur_en  = 1'b0;
   bit          corrupt [0:63];
   logic [31:0] corrupt_xor = 32'h1;
   logic [15:0] t_base = '0;
   logic [31:0] t_seed = '0;
   int          wr_n = 0;
   int          rd_n = 0;
   logic [31:0] mem [0:16383];

   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_data = '0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_addr = '0;
   logic [31:0] prev_data = '0;
   logic [1:0]  prev_cmd = '0;

   always @(negedge clk) begin
      logic [15:0] ea;
      logic [31:0] d;
      if (reset) begin
         pend                  = 1'b0;
         prev_stall            = 1'b0;
         avm.avm_readdatavalid = 1'b0;
         avm.avm_waitrequest   = 1'b0;
         avm.avm_readdata      = '0;
      end else begin
         check("rw_excl", {31'b0, avm.avm_read & avm.avm_write}, 32'h0);
         if (prev_stall) begin
            check("hold_addr", {16'b0, avm.avm_address}, {16'b0, prev_addr});
            check("hold_data", avm.avm_writedata, prev_data);
            check("hold_cmd", {30'b0, avm.avm_read, avm.avm_write}, {30'b0, prev_cmd});
         end
         avm.avm_readdatavalid = 1'b0;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               avm.avm_readdatavalid = 1'b1;
               avm.avm_readdata      = pend_data;
               pend                  = 1'b0;
            end
         end else if (spur_en && $urandom_range(0, 9) == 0) begin
            avm.avm_readdatavalid = 1'b1;
            avm.avm_readdata      = $urandom;
         end
         avm.avm_waitrequest = ($urandom_range(0, 99) < wait_pct);
         if ((avm.avm_read || avm.avm_write) && !avm.avm_waitrequest) begin
            if (avm.avm_write) begin
               ea = t_base + 16'(wr_n * 4);
               check("wr_addr", {16'b0, avm.avm_address}, {16'b0, ea});
               check("wr_data", avm.avm_writedata, t_seed + 32'(wr_n));
               check("wr_be", {28'b0, avm.avm_byteenable}, 32'hF);
               mem[avm.avm_address[15:2]] = avm.avm_writedata;
               wr_n++;
            end else begin
               ea = t_base + 16'(rd_n * 4);
               check("rd_addr", {16'b0, avm.avm_address}, {16'b0, ea});
               d = mem[avm.avm_address[15:2]];
               if (rd_n < 64 && corrupt[rd_n]) d = d ^ corrupt_xor;
               pend      = 1'b1;
               pend_cnt  = rd_lat;
               pend_data = d;
               rd_n++;
            end
         end
         prev_stall = (avm.avm_read || avm.avm_write) && avm.avm_waitrequest;
         prev_addr  = avm.avm_address;
         prev_data  = avm.avm_writedata;
         prev_cmd   = {avm.avm_read, avm.avm_write};
      end
   end

   task automatic clear_corrupt();
      for (int i = 0; i < 64; i++) corrupt[i] = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Runs one full test; expectations come from the corruption plan and address arithmetic.
   task automatic run_test(input logic [15:0] b, input int n, input logic [31:0] s);
      int          exp_err;
      logic [15:0] exp_first;
      int          c0;
      int          t;
      logic        held_pass;
      exp_err   = 0;
      exp_first = '0;
      t_base    = {b[15:2], 2'b00};
      t_seed    = s;
      for (int i = 0; i < n; i++) begin
         if (i < 64 && corrupt[i]) begin
            if (exp_err == 0) exp_first = t_base + 16'(4 * i);
            exp_err++;
         end
      end
      wr_n       = 0;
      rd_n       = 0;
      base_addr  = b;
      word_count = CNT_W'(n);
      seed       = s;
      start      = 1'b1;
      c0         = cyc;
      step();
      check("busy_after_start", {31'b0, busy}, 32'h1);
      // Start while busy must be ignored.
      base_addr  = 16'($urandom);
      word_count = 14'd7;
      seed       = $urandom;
      step();
      start = 1'b0;
      t = 0;
      while (!done && t < 4000) begin
         if (n > 0) check("busy_during_run", {31'b0, busy}, 32'h1);
         step();
         t++;
      end
      if (!done) begin
         check("done_timeout", 32'h0, 32'h1);
         reset = 1'b1;
         step();
         reset = 1'b0;
         return;
      end
      if (n == 0) check("zero_cnt_latency", 32'(cyc - c0), 32'd2);
      check("busy_at_done", {31'b0, busy}, 32'h0);
      check("pass", {31'b0, pass}, {31'b0, exp_err == 0});
      check("err_count", {16'b0, err_count}, 32'(exp_err));
      check("first_err_addr", {16'b0, first_err_addr}, {16'b0, exp_first});
      check("write_count", 32'(wr_n), 32'(n));
      check("read_count", 32'(rd_n), 32'(n));
      held_pass = (exp_err == 0);
      // Start during the done cycle must be ignored too.
      start      = 1'b1;
      word_count = 14'd5;
      step();
      start = 1'b0;
      check("done_one_cycle", {31'b0, done}, 32'h0);
      check("idle_after_done", {31'b0, busy}, 32'h0);
      step();
      check("start_in_done_ignored", {31'b0, busy}, 32'h0);
      check("pass_held", {31'b0, pass}, {31'b0, held_pass});
      check("err_held", {16'b0, err_count}, 32'(exp_err));
      check("first_held", {16'b0, first_err_addr}, {16'b0, exp_first});
   endtask

   initial begin
      int t;
      clear_corrupt();
      reset      = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      seed       = '0;
      repeat (3) @(posedge clk);
      step();
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_pass", {31'b0, pass}, 32'h0);
      check("rst_err", {16'b0, err_count}, 32'h0);
      check("rst_first", {16'b0, first_err_addr}, 32'h0);
      check("rst_addr", {16'b0, avm.avm_address}, 32'h0);
      check("rst_cmd", {30'b0, avm.avm_read, avm.avm_write}, 32'h0);
      reset = 1'b0;
      step();

      // Basic zero-wait run
      run_test(16'h0000, 4, 32'h0000_1000);
      // Bit 0 flipped on word 2
      corrupt[2]  = 1'b1;
      corrupt_xor = 32'h1;
      run_test(16'h0000, 4, 32'h0000_1000);
      clear_corrupt();
      // Stalls and read latency 3
      wait_pct = 50;
      rd_lat   = 3;
      run_test(16'h0200, 16, 32'hDEAD_0000);
      wait_pct = 0;
      rd_lat   = 1;
      // Empty range
      run_test(16'h0040, 0, 32'h1234_5678);
      // Address and data wrap
      run_test(16'hFFF8, 4, 32'hFFFF_FFFE);

      // Reset in the middle of the write phase
      t_base = 16'h0100;
      t_seed = 32'h5555_0000;
      wr_n = 0;
      rd_n = 0;
      base_addr  = 16'h0100;
      word_count = 14'd16;
      seed       = 32'h5555_0000;
      start      = 1'b1;
      step();
      start = 1'b0;
      t = 0;
      while (!(avm.avm_write && avm.avm_address == 16'h0114) && t < 100) begin
         step();
         t++;
      end
      check("reach_idx5", {31'b0, avm.avm_write}, 32'h1);
      reset = 1'b1;
      step();
      check("abort_write", {31'b0, avm.avm_write}, 32'h0);
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_err", {16'b0, err_count}, 32'h0);
      check("abort_done", {31'b0, done}, 32'h0);
      reset = 1'b0;
      step();
      run_test(16'h0100, 16, 32'h5555_0000);

      // Randomized runs with stray readdatavalid pulses
      spur_en = 1'b1;
      for (int r = 0; r < 10; r++) begin
         clear_corrupt();
         for (int i = 0; i < 64; i++) corrupt[i] = ($urandom_range(0, 3) == 0);
         corrupt_xor = $urandom | 32'h1;
         wait_pct    = int'($urandom_range(0, 70));
         rd_lat      = int'($urandom_range(1, 4));
         run_test(16'($urandom), int'($urandom_range(1, 40)), $urandom);
      end
      spur_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
